// File: rtl/mac_accumulator_if.sv
// Sample/coefficient input bundle and frame-sum output bundle for mac_accumulator.
// The o_ovf signal exists only when MAC_ACCUM_OVF_DET_EN is defined.
interface mac_accumulator_if #(
  parameter int unsigned IWID = 16,
  parameter int unsigned AWID = 40
);

  logic                   i_ce;
  logic signed [IWID-1:0] i_sample;
  logic signed [IWID-1:0] i_coef;
  logic                   i_clear;

  logic                   o_ce;
  logic signed [AWID-1:0] o_acc;
  logic                   o_busy;

`ifdef MAC_ACCUM_OVF_DET_EN
  logic                   o_ovf;

  modport master (
    output i_ce, i_sample, i_coef, i_clear,
    input  o_ce, o_acc, o_busy, o_ovf
  );

  modport slave (
    input  i_ce, i_sample, i_coef, i_clear,
    output o_ce, o_acc, o_busy, o_ovf
  );
`else
  modport master (
    output i_ce, i_sample, i_coef, i_clear,
    input  o_ce, o_acc, o_busy
  );

  modport slave (
    input  i_ce, i_sample, i_coef, i_clear,
    output o_ce, o_acc, o_busy
  );
`endif

endinterface

// File: rtl/mac_accumulator.sv
// Two-stage signed multiply-accumulate: sums NACC products per frame, one o_ce per frame.
// Optional per-frame signed-overflow flag o_ovf when MAC_ACCUM_OVF_DET_EN is defined.
module mac_accumulator #(
  parameter int unsigned IWID = 16,
  parameter int unsigned AWID = 40,
  parameter int unsigned NACC = 8
) (
  input logic              i_clk,
  input logic              i_reset_n,
  mac_accumulator_if.slave bus
);

  localparam int unsigned PWID = 2 * IWID;
  localparam int unsigned CWID = $clog2(NACC);
  localparam logic [CWID-1:0] LastTap = CWID'(NACC - 1);

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  state_e                 state_q;
  logic signed [PWID-1:0] p_q;
  logic                   p_vld_q;
  logic signed [AWID-1:0] acc_q;
  logic [CWID-1:0]        cnt_q;
  logic                   o_ce_q;
  logic signed [AWID-1:0] o_acc_q;

  logic signed [AWID-1:0] p_ext;
  logic signed [AWID-1:0] sum;

  // Size cast on a signed operand sign-extends the product to accumulator width.
  assign p_ext = AWID'(p_q);
  assign sum   = acc_q + p_ext;

`ifdef MAC_ACCUM_OVF_DET_EN
  logic ovf_q;
  logic o_ovf_q;
  logic add_ovf;

  // Same-sign operands producing a different-sign result means the add wrapped.
  assign add_ovf = (acc_q[AWID-1] == p_ext[AWID-1]) && (sum[AWID-1] != acc_q[AWID-1]);
  assign bus.o_ovf = o_ovf_q;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_ce_q  <= 1'b0;
      o_acc_q <= '0;
`ifdef MAC_ACCUM_OVF_DET_EN
      ovf_q   <= 1'b0;
      o_ovf_q <= 1'b0;
`endif
    end else if (bus.i_clear) begin
      // Abort the frame; the last completed sum stays visible on o_acc.
      state_q <= StIdle;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_ce_q  <= 1'b0;
`ifdef MAC_ACCUM_OVF_DET_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      p_vld_q <= bus.i_ce;
      if (bus.i_ce) begin
        p_q <= PWID'(bus.i_sample) * PWID'(bus.i_coef);
      end
      o_ce_q <= 1'b0;

      if (p_vld_q) begin
        case (state_q)
          StIdle: begin
            acc_q   <= p_ext;
            cnt_q   <= CWID'(1);
            state_q <= StAccum;
`ifdef MAC_ACCUM_OVF_DET_EN
            ovf_q   <= 1'b0;
`endif
          end
          StAccum: begin
            if (cnt_q == LastTap) begin
              o_acc_q <= sum;
              o_ce_q  <= 1'b1;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
`ifdef MAC_ACCUM_OVF_DET_EN
              o_ovf_q <= ovf_q | add_ovf;
              ovf_q   <= 1'b0;
`endif
            end else begin
              acc_q <= sum;
              cnt_q <= cnt_q + CWID'(1);
`ifdef MAC_ACCUM_OVF_DET_EN
              ovf_q <= ovf_q | add_ovf;
`endif
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.o_ce   = o_ce_q;
  assign bus.o_acc  = o_acc_q;
  assign bus.o_busy = (state_q == StAccum) | p_vld_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator; with MAC_ACCUM_OVF_DET_EN it builds
// the DUT at AWID=32 and exercises the overflow flag instead of the 2^33 full-scale frame.
module tb_mac_accumulator;

  localparam int unsigned IWID = 16;
`ifdef MAC_ACCUM_OVF_DET_EN
  localparam int unsigned AWID = 32;
`else
  localparam int unsigned AWID = 40;
`endif
  localparam int unsigned NACC = 8;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;

  mac_accumulator_if #(.IWID(IWID), .AWID(AWID)) bus ();

  mac_accumulator #(
    .IWID(IWID),
    .AWID(AWID),
    .NACC(NACC)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  int                 pulses   = 0;
  int                 last_cyc = 0;
  int                 prev_cyc = 0;
  logic signed [63:0] last_acc = '0;
  logic signed [63:0] prev_acc = '0;

  always @(negedge i_clk) begin
    if (bus.o_ce === 1'b1) begin
      pulses   = pulses + 1;
      prev_cyc = last_cyc;
      prev_acc = last_acc;
      last_cyc = cyc;
      last_acc = bus.o_acc;
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic ce, input int s, input int c, input logic clr);
    bus.i_ce     = ce;
    bus.i_sample = IWID'(s);
    bus.i_coef   = IWID'(c);
    bus.i_clear  = clr;
    @(posedge i_clk);
    #1;
  endtask

  int                 p0;
  logic signed [63:0] held_acc;

  initial begin
    bus.i_ce     = 1'b0;
    bus.i_sample = '0;
    bus.i_coef   = '0;
    bus.i_clear  = 1'b0;

    // Reset held for 3 cycles against live strobes.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, i * 123 + 5, -i - 3, 1'b0);
      check("rst_o_ce", bus.o_ce, 0);
      check("rst_o_acc", bus.o_acc, 0);
      check("rst_o_busy", bus.o_busy, 0);
    end
    bus.i_ce  = 1'b0;
    i_reset_n = 1'b1;
    tick(1'b0, 0, 0, 1'b0);
    check("post_rst_busy", bus.o_busy, 0);

    // Samples 1..8 times 2, back to back.
    p0 = pulses;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, i, 2, 1'b0);
      check("f1_busy", bus.o_busy, 1);
      check("f1_no_ce", bus.o_ce, 0);
    end
    tick(1'b0, 0, 0, 1'b0);
    check("f1_o_ce", bus.o_ce, 1);
    check("f1_o_acc", bus.o_acc, 72);
    check("f1_busy_done", bus.o_busy, 0);
    tick(1'b0, 0, 0, 1'b0);
    check("f1_ce_drop", bus.o_ce, 0);
    check("f1_acc_hold", bus.o_acc, 72);
    check("f1_pulses", pulses - p0, 1);

    // Strobe every 3rd cycle.
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("gap_no_early_ce", pulses - p0, 0);
      tick(1'b1, -100, 100, 1'b0);
      tick(1'b0, 0, 0, 1'b0);
      if (i == 3) check("gap_busy_hold", bus.o_busy, 1);
      tick(1'b0, 0, 0, 1'b0);
    end
    tick(1'b0, 0, 0, 1'b0);
    check("gap_pulses", pulses - p0, 1);
    check("gap_o_acc", last_acc, -80000);

`ifdef MAC_ACCUM_OVF_DET_EN
    // Full-scale products overflow a 32-bit accumulator.
    for (int i = 0; i < 8; i++) tick(1'b1, -32768, -32768, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    check("ovf_o_ce", bus.o_ce, 1);
    check("ovf_flag_set", bus.o_ovf, 1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1, 1, 1'b0);
    tick(1'b0, 0, 0, 1'b0);
    check("ovf2_o_ce", bus.o_ce, 1);
    check("ovf2_o_acc", bus.o_acc, 8);
    check("ovf2_flag_clr", bus.o_ovf, 0);
    held_acc = 8;
`else
    // Sixteen full-scale products: two frames, each exactly 2^33.
    p0 = pulses;
    for (int i = 0; i < 16; i++) tick(1'b1, -32768, -32768, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0);
    check("fs_pulses", pulses - p0, 2);
    check("fs_spacing", last_cyc - prev_cyc, 8);
    check("fs_acc_first", prev_acc, 64'sd8589934592);
    check("fs_acc_second", last_acc, 64'sd8589934592);
    held_acc = 64'sd8589934592;
`endif

    // Abort mid-frame; the strobe coinciding with i_clear is dropped.
    p0 = pulses;
    for (int i = 0; i < 5; i++) tick(1'b1, 7, 7, 1'b0);
    tick(1'b1, 9, 9, 1'b1);
    check("clr_o_ce", bus.o_ce, 0);
    check("clr_acc_hold", bus.o_acc, held_acc);
    check("clr_busy", bus.o_busy, 0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1, 1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0);
    check("clr_pulses", pulses - p0, 1);
    check("clr_o_acc", last_acc, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
